// File: rtl/risc_mem_pkg.sv
// Shared encodings for the data-memory load/store path.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package risc_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Right-justified lane masks; shifted into place by the byte offset
    localparam logic [31:0] LANE_MASK_B = 32'h0000_00ff;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_ffff;
    localparam logic [31:0] LANE_MASK_W = 32'hffff_ffff;

    // Load/store sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    // Illegal size, or an access that does not sit on its natural boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction with sign/zero extension for loads, lane merge into the old word for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
    import risc_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] shifted;
    logic        sext;

    // Bit offset and in-place mask of the addressed lane (little-endian)
    always_comb begin
        shamt     = 5'd0;
        lane_mask = LANE_MASK_W;
        case (size)
            SZ_BYTE: begin
                shamt     = {addr_lo, 3'b000};
                lane_mask = LANE_MASK_B << shamt;
            end
            SZ_HALF: begin
                shamt     = {addr_lo[1], 4'b0000};
                lane_mask = LANE_MASK_H << shamt;
            end
            default: begin
                shamt     = 5'd0;
                lane_mask = LANE_MASK_W;
            end
        endcase
    end

    assign shifted = old_word >> shamt;

    // Right-justify the lane and fill the upper bits from its sign or with zero
    always_comb begin
        sext      = 1'b0;
        load_data = old_word;
        case (size)
            SZ_BYTE: begin
                sext      = ~is_unsigned & shifted[7];
                load_data = {{24{sext}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sext      = ~is_unsigned & shifted[15];
                load_data = {{16{sext}}, shifted[15:0]};
            end
            default: begin
                sext      = 1'b0;
                load_data = old_word;
            end
        endcase
    end

    // Keep the untouched lanes of the old word, drop the new lane(s) in place
    assign merged_word = (old_word & ~lane_mask) | ((store_data << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores as read-modify-write.
// Latency accept->rsp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module load_store_unit
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // lane logic is 32-bit only
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state;
    logic [1:0]        l_size;
    logic              l_uns;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              err_q;

    logic              accept;
    logic              req_bad;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign req_bad   = is_misaligned(req_size, req_addr[1:0]);

    // Memory-side outputs come only from registered state, never from request inputs
    assign mem_we    = (state == ST_STORE);
    assign mem_addr  = (state == ST_IDLE) ? '0 : {l_addr[ADDR_W-1:2], 2'b00};
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) & err_q;

    lsu_lane_align u_align (
        .size        (l_size),
        .is_unsigned (l_uns),
        .addr_lo     (l_addr[1:0]),
        .old_word    (mem_rdata),
        .store_data  (l_wdata),
        .load_data   (lane_load),
        .merged_word (lane_merged)
    );

    // Request latch: captured only on accept so inputs are ignored while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_size  <= SZ_BYTE;
            l_uns   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            l_size  <= req_size;
            l_uns   <= req_unsigned;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            err_q   <= req_bad;
        end
    end

    // Sequencer; direction is carried by the state so no separate write flag is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_bad)               state <= ST_RESP;
                        else if (!req_we)          state <= ST_LOAD;
                        else if (req_size == SZ_WORD) state <= ST_STORE;
                        else                       state <= ST_RMW_RD;
                    end
                end
                ST_LOAD:   state <= ST_RESP;
                ST_RMW_RD: state <= ST_STORE;
                ST_STORE:  state <= ST_RESP;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Write word: raw store data for word stores, merged old word for sub-word stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata <= '0;
        end else if (accept && !req_bad && req_we && (req_size == SZ_WORD)) begin
            mem_wdata <= req_wdata;
        end else if (state == ST_RMW_RD) begin
            mem_wdata <= lane_merged;
        end
    end

    // Response data changes only on the edge entering RESP, so it holds between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (state == ST_LOAD) begin
            rsp_rdata <= lane_load;
        end else if (state == ST_STORE) begin
            rsp_rdata <= '0;
        end else if (accept && req_bad) begin
            rsp_rdata <= '0;
        end
    end

endmodule
